// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the RV32M muldiv unit.
// The core drives the master side; the unit sits on the slave side.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            abort;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, abort, funct3,
    output operand_a, operand_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, abort, funct3,
    input  operand_a, operand_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide.
// One iteration per clock on operand magnitudes, sign fix-up at the end.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int W2 = 2 * XLEN;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             sa_q, sb_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [W2-1:0]    acc_q;
  logic [XLEN-1:0]  result_q;
  logic [4:0]       rd_q;

  logic            accept;
  logic            a_signed, b_signed;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_diff;
  logic [W2-1:0]   acc_next;

  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic [XLEN-1:0] fix_val;

  assign accept = bus.start & ~bus.abort &
                  ((state_q == IDLE) | (state_q == DONE));

  always_comb begin
    a_signed = (bus.funct3 == F_MULH)   |
               (bus.funct3 == F_MULHSU) |
               (bus.funct3 == F_DIV)    |
               (bus.funct3 == F_REM);
    b_signed = (bus.funct3 == F_MULH) |
               (bus.funct3 == F_DIV)  |
               (bus.funct3 == F_REM);
    sgn_a = a_signed & bus.operand_a[XLEN-1];
    sgn_b = b_signed & bus.operand_b[XLEN-1];
    a_mag = sgn_a ? -bus.operand_a : bus.operand_a;
    b_mag = sgn_b ? -bus.operand_b : bus.operand_b;
  end

  // Divide-by-zero and INT_MIN/-1 finish straight away, no iterations.
  always_comb begin
    div_zero = bus.funct3[2] & (bus.operand_b == '0);
    div_ovf  = bus.funct3[2] & ~bus.funct3[0] &
               (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}}) &
               (bus.operand_b == '1);
    special  = div_zero | div_ovf;
    special_val = '0;
    if (div_zero)
      special_val = bus.funct3[1] ? bus.operand_a : '1;
    else if (div_ovf)
      special_val = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // acc holds {hi, multiplier} for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} +
               (acc_q[0] ? {1'b0, a_q} : '0);
    div_diff = acc_q[W2-1:XLEN-1] - {1'b0, b_q};
    if (!op_q[2])
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_next = {acc_q[W2-2:0], 1'b0};
  end

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sa_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
    fix_val  = rem_fix;
    unique case (1'b1)
      (op_q == F_MUL):           fix_val = prod_fix[XLEN-1:0];
      (!op_q[2] && op_q != 3'b0): fix_val = prod_fix[W2-1:XLEN];
      (op_q[2] && !op_q[1]):      fix_val = quo_fix;
      default:                    fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept)  state_d = special ? DONE : CALC;
        else         state_d = IDLE;
      end
      CALC: if (cnt_q == '1) state_d = FIX;
      FIX:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  always_comb begin
    bus.busy   = (state_q == CALC) | (state_q == FIX);
    bus.done   = (state_q == DONE);
    bus.result = result_q;
    bus.rd_out = rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      op_q  <= bus.funct3;
      sa_q  <= sgn_a;
      sb_q  <= sgn_b;
      a_q   <= a_mag;
      b_q   <= b_mag;
      acc_q <= {{XLEN{1'b0}}, bus.funct3[2] ? a_mag : b_mag};
      rd_q  <= bus.rd_in;
      if (special) result_q <= special_val;
    end else if (!bus.abort) begin
      if (state_q == CALC) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == FIX) begin
        result_q <= fix_val;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, specials, abort,
// back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bus.start     = 1'b1;
    bus.funct3    = f;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.rd_in     = rd;
    step();
    bus.start     = 1'b0;
    bus.funct3    = 3'b111;
    bus.operand_a = 32'hA5A5_5A5A;
    bus.operand_b = 32'h1234_5678;
    bus.rd_in     = 5'd31;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output int bcnt);
    issue(f, a, b, rd);
    lat  = 1;
    bcnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.result !== 32'h0 || bus.rd_out !== 5'h0)
      $display("FAIL reset: busy=%b done=%b result=%h rd=%h want 0/0/0/0",
               bus.busy, bus.done, bus.result, bus.rd_out);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_mul();
    int lat, bc;
    do_op(3'b000, 32'd7, 32'd6, 5'd5, lat, bc);
    total++;
    if (lat !== 34) $display("FAIL mul_lat: got %0d want 34", lat);
    else passed++;
    total++;
    if (bus.result !== 32'd42)
      $display("FAIL mul_res: got %h want %h", bus.result, 32'd42);
    else passed++;
    total++;
    if (bus.rd_out !== 5'd5)
      $display("FAIL mul_rd: got %0d want 5", bus.rd_out);
    else passed++;
    total++;
    if (bc !== 33) $display("FAIL mul_busy: got %0d want 33", bc);
    else passed++;
    step();
    total++;
    if (bus.done !== 1'b0 || bus.result !== 32'd42)
      $display("FAIL mul_hold: done=%b result=%h want 0/%h",
               bus.done, bus.result, 32'd42);
    else passed++;
  endtask

  task automatic test_mulh();
    int lat, bc;
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, lat, bc);
    total++;
    if (bus.result !== 32'h0 || lat !== 34)
      $display("FAIL mulh: got %h lat %0d want 00000000 lat 34",
               bus.result, lat);
    else passed++;
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, lat, bc);
    total++;
    if (bus.result !== 32'hFFFF_FFFE)
      $display("FAIL mulhu: got %h want fffffffe", bus.result);
    else passed++;
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, lat, bc);
    total++;
    if (bus.result !== 32'hFFFF_FFFF)
      $display("FAIL mulhsu: got %h want ffffffff", bus.result);
    else passed++;
  endtask

  task automatic test_div();
    int lat, bc;
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, lat, bc);
    total++;
    if (bus.result !== 32'hFFFF_FFFD || lat !== 34)
      $display("FAIL div: got %h lat %0d want fffffffd lat 34",
               bus.result, lat);
    else passed++;
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, lat, bc);
    total++;
    if (bus.result !== 32'hFFFF_FFFF)
      $display("FAIL rem: got %h want ffffffff", bus.result);
    else passed++;
    do_op(3'b101, 32'd100, 32'd7, 5'd6, lat, bc);
    total++;
    if (bus.result !== 32'd14)
      $display("FAIL divu: got %h want %h", bus.result, 32'd14);
    else passed++;
    do_op(3'b111, 32'd100, 32'd7, 5'd7, lat, bc);
    total++;
    if (bus.result !== 32'd2)
      $display("FAIL remu: got %h want %h", bus.result, 32'd2);
    else passed++;
  endtask

  task automatic test_special();
    int lat, bc;
    do_op(3'b101, 32'd5, 32'd0, 5'd8, lat, bc);
    total++;
    if (bus.result !== 32'hFFFF_FFFF || lat !== 1 || bc !== 0)
      $display("FAIL divu_zero: got %h lat %0d busy %0d want ffffffff 1 0",
               bus.result, lat, bc);
    else passed++;
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, lat, bc);
    total++;
    if (bus.result !== 32'h8000_0000 || lat !== 1 || bc !== 0)
      $display("FAIL div_ovf: got %h lat %0d busy %0d want 80000000 1 0",
               bus.result, lat, bc);
    else passed++;
    do_op(3'b110, 32'd5, 32'd0, 5'd9, lat, bc);
    total++;
    if (bus.result !== 32'd5 || lat !== 1 || bc !== 0 || bus.rd_out !== 5'd9)
      $display("FAIL rem_zero: got %h lat %0d busy %0d rd %0d want 5 1 0 9",
               bus.result, lat, bc, bus.rd_out);
    else passed++;
    step();
  endtask

  task automatic test_start_ignored();
    int lat;
    issue(3'b000, 32'd7, 32'd6, 5'd3);
    lat = 1;
    repeat (4) begin step(); lat++; end
    bus.start     = 1'b1;
    bus.funct3    = 3'b100;
    bus.operand_a = 32'd99;
    bus.operand_b = 32'd3;
    bus.rd_in     = 5'd9;
    step();
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 200) begin step(); lat++; end
    total++;
    if (lat !== 34 || bus.result !== 32'd42 || bus.rd_out !== 5'd3)
      $display("FAIL start_busy: lat %0d res %h rd %0d want 34 %h 3",
               lat, bus.result, bus.rd_out, 32'd42);
    else passed++;
    step();
  endtask

  task automatic test_abort();
    int lat, bc, seen;
    logic [31:0] prior;
    prior = bus.result;
    issue(3'b101, 32'd100, 32'd7, 5'd11);
    repeat (9) step();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== prior)
      $display("FAIL abort_idle: busy=%b done=%b res=%h want 0 0 %h",
               bus.busy, bus.done, bus.result, prior);
    else passed++;
    seen = 0;
    repeat (40) begin
      if (bus.done || bus.busy) seen++;
      step();
    end
    total++;
    if (seen !== 0 || bus.result !== prior)
      $display("FAIL abort_quiet: active %0d res %h want 0 %h",
               seen, bus.result, prior);
    else passed++;
    do_op(3'b000, 32'd3, 32'd3, 5'd12, lat, bc);
    total++;
    if (bus.result !== 32'd9 || lat !== 34)
      $display("FAIL abort_next: got %h lat %0d want %h 34",
               bus.result, lat, 32'd9);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_op(3'b000, 32'd2, 32'd3, 5'd13, lat, bc);
    total++;
    if (bus.result !== 32'd6 || bus.done !== 1'b1)
      $display("FAIL b2b_first: got %h done %b want %h 1",
               bus.result, bus.done, 32'd6);
    else passed++;
    do_op(3'b000, 32'd4, 32'd5, 5'd14, lat, bc);
    total++;
    if (bus.result !== 32'd20 || lat !== 34 || bus.rd_out !== 5'd14)
      $display("FAIL b2b_second: got %h lat %0d rd %0d want %h 34 14",
               bus.result, lat, bus.rd_out, 32'd20);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    issue(3'b000, 32'd9, 32'd9, 5'd15);
    repeat (10) step();
    total++;
    if (bus.busy !== 1'b1)
      $display("FAIL rst_mid_busy: got %b want 1", bus.busy);
    else passed++;
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.result !== 32'h0 || bus.rd_out !== 5'h0)
      $display("FAIL rst_mid: busy=%b done=%b res=%h rd=%h want 0/0/0/0",
               bus.busy, bus.done, bus.result, bus.rd_out);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.funct3    = 3'b000;
    bus.operand_a = 32'h0;
    bus.operand_b = 32'h0;
    bus.rd_in     = 5'h0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
